booth_divider: RTL and testbench
================================

// Module: booth_divider
// PURPOSE
//  Sequential signed divider: 2W-bit dividend / W-bit divisor -> W-bit quotient + W-bit remainder.
//  Inverse companion of the Booth multiplier: accepts its 2W-bit product format and returns operands.
//  Same start/busy handshake as the multiplier, plus a one-cycle done strobe. Sits in the ALU datapath.
// PARAMETERS
//  W   8   operand width; dividend is 2W bits, quotient/remainder W bits (W >= 2)
// PORTS
//  clk    in   1     rising-edge clock
//  rst_n  in   1     asynchronous active-low reset
//  start  in   1     request; sampled only while busy==0
//  a      in   2W    signed dividend (two's complement)
//  b      in   W     signed divisor (two's complement)
//  quo    out  W     signed quotient, truncated toward zero
//  rem    out  W     signed remainder, sign of dividend (or 0)
//  busy   out  1     high from accept edge until result edge
//  done   out  1     one-cycle pulse; quo/rem/ovf/dbz valid from this cycle, held until next accept
//  ovf    out  1     quotient not representable in W signed bits (also set on divide-by-zero)
//  dbz    out  1     divisor was zero
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; quo=0, rem=0, busy=0, done=0, ovf=0, dbz=0; internals cleared.
//  Reset mid-operation aborts; no done pulse; next start after release accepted normally.
//  FSM IDLE -> PREP -> RUN (W cycles) -> FIX -> IDLE.
//   IDLE: start&&!busy at edge 0 -> latch a,b; busy<=1; done<=0; -> PREP. start while busy: ignored.
//   PREP (edge 1): magA=|a| (2W unsigned, 0x8000.. valid), magB=|b| (W unsigned); sq=a[2W-1]^b[W-1],
//         sr=a[2W-1]. dbz<=(b==0). Unsigned pre-overflow: uovf = (magA[2W-1:W] >= magB).
//         R(W+1 bits)<=magA[2W-1:W], Q<=magA[W-1:0], i<=0.
//   RUN (edges 2..W+1): restoring step per cycle: T={R[W-1:0],Q[W-1]}-{1'b0,magB};
//         if T>=0: R<=T, Q<={Q[W-2:0],1}; else R<={R[W-1:0],Q[W-1]}, Q<={Q[W-2:0],0}. i<=i+1; exit at i==W-1.
//   FIX (edge W+2): qs = sq ? -Q : Q; rs = sr ? -R[W-1:0] : R[W-1:0].
//         Signed overflow: sq==0 && Q>2^(W-1)-1, or sq==1 && Q>2^(W-1).
//         If dbz: quo=0, rem=0, ovf=1. Else if uovf or signed overflow: quo=0, rem=0, ovf=1.
//         Else quo=qs, rem=rs, ovf=0. busy<=0, done<=1 same edge; -> IDLE.
//  done deasserts on next edge. Latency fixed: accept edge to done edge = W+2 edges, all cases incl. dbz.
//  Back-to-back: start sampled in the cycle after done is accepted (busy already 0).
//  Outputs quo/rem/ovf/dbz hold last result while idle; overwritten only at FIX.
//  Invariant when ovf==0: a == quo*b + rem, |rem| < |b|.
// STRUCTURE
//  Shared package alu_pkg: state enum div_state_t {IDLE, PREP, RUN, FIX}; default width ALU_W=8.
//  Sub-module div_restore_step (combinational, W param): in R,Qmsb,magB -> out R_next, qbit.
//  Top holds FSM, counter, operand/magnitude registers, sign/overflow fix-up.
// TESTING (W=8)
//  a=0x0064(100), b=0x07 -> quo=0x0E, rem=0x02, ovf=0, dbz=0, done exactly 10 edges after accept.
//  a=0xFF9C(-100), b=0x07 -> quo=0xF2(-14), rem=0xFE(-2); a=0x0064, b=0xF9(-7) -> quo=0xF2, rem=0x02.
//  a=0xC000(-16384), b=0x80(-128) -> ovf=1, quo=0, rem=0; a=0xC000, b=0x7F... use b=0x80 with a=0x4000 -> quo=0x80, rem=0, ovf=0.
//  a=0x0800, b=0x08 (uovf) -> ovf=1; a=0x0005, b=0x00 -> dbz=1, ovf=1, quo=0, rem=0, done at edge 10.
//  start pulsed during busy with different operands -> ignored, first result unchanged, single done.
//  rst_n low at RUN cycle 4 -> busy=0, done=0, all outputs 0 immediately; new start 100/7 -> 0x0E/0x02.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared ALU definitions: default operand width and divider FSM states.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam int ALU_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    RUN  = 2'd2,
    FIX  = 2'd3
  } div_state_t;

endpackage

`default_nettype wire

// File: rtl/div_restore_step.sv
// ---------------------------------------------------------------------------
// div_restore_step
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor magnitude if it fits.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div_restore_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] r_i,
  input  logic         qmsb_i,
  input  logic [W-1:0] magb_i,
  output logic [W-1:0] r_next_o,
  output logic         qbit_o
);

  logic [W:0]   shifted;
  logic [W-1:0] diff;

  // Trial subtraction; the low W bits of the difference are exact whenever
  // the divisor fits, because the result is then smaller than magb_i.
  always_comb begin
    shifted  = {r_i, qmsb_i};
    qbit_o   = (shifted >= {1'b0, magb_i});
    diff     = shifted[W-1:0] - magb_i;
    r_next_o = qbit_o ? diff : shifted[W-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/booth_divider.sv
// ---------------------------------------------------------------------------
// booth_divider
// Sequential signed divider: 2W-bit dividend / W-bit divisor giving a W-bit
// quotient (truncated toward zero) and a W-bit remainder (sign of dividend).
// Fixed latency of W+2 edges from accept to the done strobe.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module booth_divider
  import alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*W-1:0] a,
  input  logic [W-1:0]   b,
  output logic [W-1:0]   quo,
  output logic [W-1:0]   rem,
  output logic           busy,
  output logic           done,
  output logic           ovf,
  output logic           dbz
);

  localparam int         CW       = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_I = CW'(W - 1);
  localparam logic [W-1:0] QMAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] QMAX_NEG = {1'b1, {(W-1){1'b0}}};

  div_state_t     state_q, state_d;
  logic [2*W-1:0] a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   magb_q, magb_d;
  // Partial remainder is kept at W bits: once the pre-overflow check passes
  // it always stays below magb, and when it fails the result is discarded.
  logic [W-1:0]   r_q, r_d;
  logic [W-1:0]   q_q, q_d;
  logic [CW-1:0]  i_q, i_d;
  logic           sq_q, sq_d;
  logic           sr_q, sr_d;
  logic           zdiv_q, zdiv_d;
  logic           uovf_q, uovf_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   rem_q, rem_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           ovf_q, ovf_d;
  logic           dbz_q, dbz_d;

  logic [2*W-1:0] w_maga;
  logic [W-1:0]   w_magb;
  logic [W-1:0]   w_r_next;
  logic           w_qbit;
  logic [W-1:0]   w_qs;
  logic [W-1:0]   w_rs;
  logic           w_sovf;

  div_restore_step #(.W(W)) u_step (
    .r_i      (r_q),
    .qmsb_i   (q_q[W-1]),
    .magb_i   (magb_q),
    .r_next_o (w_r_next),
    .qbit_o   (w_qbit)
  );

  // Next-state logic, datapath updates and sign/overflow fix-up.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    magb_d  = magb_q;
    r_d     = r_q;
    q_d     = q_q;
    i_d     = i_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    zdiv_d  = zdiv_q;
    uovf_d  = uovf_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;

    w_maga = a_q[2*W-1] ? -a_q : a_q;
    w_magb = b_q[W-1]   ? -b_q : b_q;
    w_qs   = sq_q ? -q_q : q_q;
    w_rs   = sr_q ? -r_q : r_q;
    w_sovf = sq_q ? (q_q > QMAX_NEG) : (q_q > QMAX_POS);

    case (state_q)
      IDLE: begin
        if (start && !busy_q) begin
          a_d     = a;
          b_d     = b;
          busy_d  = 1'b1;
          state_d = PREP;
        end
      end
      PREP: begin
        magb_d  = w_magb;
        sq_d    = a_q[2*W-1] ^ b_q[W-1];
        sr_d    = a_q[2*W-1];
        zdiv_d  = (b_q == '0);
        uovf_d  = (w_maga[2*W-1:W] >= w_magb);
        r_d     = w_maga[2*W-1:W];
        q_d     = w_maga[W-1:0];
        i_d     = '0;
        state_d = RUN;
      end
      RUN: begin
        r_d = w_r_next;
        q_d = {q_q[W-2:0], w_qbit};
        i_d = i_q + 1'b1;
        if (i_q == LAST_I) begin
          state_d = FIX;
        end
      end
      FIX: begin
        dbz_d = zdiv_q;
        if (zdiv_q || uovf_q || w_sovf) begin
          quo_d = '0;
          rem_d = '0;
          ovf_d = 1'b1;
        end else begin
          quo_d = w_qs;
          rem_d = w_rs;
          ovf_d = 1'b0;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      magb_q  <= '0;
      r_q     <= '0;
      q_q     <= '0;
      i_q     <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      zdiv_q  <= 1'b0;
      uovf_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      magb_q  <= magb_d;
      r_q     <= r_d;
      q_q     <= q_d;
      i_q     <= i_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      zdiv_q  <= zdiv_d;
      uovf_q  <= uovf_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quo  = quo_q;
  assign rem  = rem_q;
  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign dbz  = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_booth_divider.sv
// ---------------------------------------------------------------------------
// tb_booth_divider
// Directed-vector bench for booth_divider at W=8.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_booth_divider;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [2*W-1:0] a;
  logic [W-1:0]   b;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;
  logic           busy;
  logic           done;
  logic           ovf;
  logic           dbz;

  int n_chk;
  int n_pass;

  booth_divider #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .quo   (quo),
    .rem   (rem),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf),
    .dbz   (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count a comparison and report a mismatch.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launch one division and wait for done; returns edges from accept to done.
  task automatic launch_and_wait(input logic [2*W-1:0] av, input logic [W-1:0] bv,
                                 output int lat);
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Directed vectors: dividend, divisor, expected quo/rem/ovf/dbz.
  localparam int NV = 8;
  logic [15:0] va   [NV] = '{16'h0064, 16'hFF9C, 16'h0064, 16'hC000,
                             16'h4000, 16'h0800, 16'h0005, 16'hFF9C};
  logic [7:0]  vb   [NV] = '{8'h07, 8'h07, 8'hF9, 8'h80,
                             8'h80, 8'h08, 8'h00, 8'hF9};
  logic [7:0]  vq   [NV] = '{8'h0E, 8'hF2, 8'hF2, 8'h00,
                             8'h80, 8'h00, 8'h00, 8'h0E};
  logic [7:0]  vr   [NV] = '{8'h02, 8'hFE, 8'h02, 8'h00,
                             8'h00, 8'h00, 8'h00, 8'hFE};
  logic        vovf [NV] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic        vdbz [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int lat;
    int dones;
    n_chk  = 0;
    n_pass = 0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_quo",  quo,  0);
    chk("rst_rem",  rem,  0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf",  ovf,  0);
    chk("rst_dbz",  dbz,  0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, each checked for result, flags and latency.
    for (int k = 0; k < NV; k++) begin
      launch_and_wait(va[k], vb[k], lat);
      chk($sformatf("v%0d_lat", k),  lat,  10);
      chk($sformatf("v%0d_quo", k),  quo,  vq[k]);
      chk($sformatf("v%0d_rem", k),  rem,  vr[k]);
      chk($sformatf("v%0d_ovf", k),  ovf,  vovf[k]);
      chk($sformatf("v%0d_dbz", k),  dbz,  vdbz[k]);
      chk($sformatf("v%0d_busy", k), busy, 0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_drop", k), done, 0);
    end

    // Result holds while idle.
    repeat (3) @(posedge clk);
    #1;
    chk("hold_quo", quo, 8'h0E);
    chk("hold_rem", rem, 8'hFE);

    // A start while busy with different operands must be ignored.
    @(negedge clk);
    a     = 16'h0064;
    b     = 8'h07;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_accept", busy, 1);
    dones = 0;
    lat   = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    a     = 16'h0800;
    b     = 8'h08;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 3;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) begin
        dones++;
        if (dones == 1) begin
          chk("ign_lat", lat, 10);
          chk("ign_quo", quo, 8'h0E);
          chk("ign_rem", rem, 8'h02);
          chk("ign_ovf", ovf, 0);
        end
      end
    end
    chk("ign_single_done", dones, 1);

    // Reset during RUN cycle 4 aborts the operation.
    @(negedge clk);
    a     = 16'hFF9C;
    b     = 8'h07;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quo",  quo,  0);
    chk("abort_rem",  rem,  0);
    chk("abort_ovf",  ovf,  0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    chk("abort_no_done", dones, 0);
    launch_and_wait(16'h0064, 8'h07, lat);
    chk("post_rst_lat", lat, 10);
    chk("post_rst_quo", quo, 8'h0E);
    chk("post_rst_rem", rem, 8'h02);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
